// File: rtl/updown_sweep_ctrl_if.sv
// Host-side control and status bundle for the up/down sweep sequencer.
// The host drives master; the sequencer sits on slave.
interface updown_sweep_ctrl_if #(
    parameter int N = 4,
    parameter int P = 4
);
    logic         start;
    logic         stop;
    logic         pause;
    logic [1:0]   mode;
    logic [N-1:0] lo;
    logic [N-1:0] hi;
    logic [P-1:0] passes;
    logic [N-1:0] q;
    logic         updown;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output start, stop, pause, mode, lo, hi, passes,
        input  q, updown, busy, done, err
    );

    modport slave (
        input  start, stop, pause, mode, lo, hi, passes,
        output q, updown, busy, done, err
    );
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Up/down sweep sequencer: owns the count register and walks it between
// latched bounds in single, counted ping-pong or continuous ping-pong modes.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for start; q and updown hold
// UP    | stepping q toward hi, one value per edge
// DOWN  | stepping q toward lo, one value per edge
module updown_sweep_ctrl #(
    parameter int N = 4,
    parameter int P = 4
) (
    input  logic clk,
    input  logic clr,
    updown_sweep_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    localparam logic [1:0]   M_UP    = 2'b00;
    localparam logic [1:0]   M_DOWN  = 2'b01;
    localparam logic [1:0]   M_COUNT = 2'b10;
    localparam logic [N-1:0] ONE_N   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [P-1:0] ONE_P   = {{(P-1){1'b0}}, 1'b1};

    state_t       state, state_n;
    logic [N-1:0] q_r, q_n;
    logic         updown_r, updown_n;
    logic         busy_r, busy_n;
    logic         done_r, done_n;
    logic         err_r, err_n;
    logic [P-1:0] pass_cnt, pass_cnt_n;
    logic [N-1:0] lo_s, lo_s_n;
    logic [N-1:0] hi_s, hi_s_n;
    logic [1:0]   mode_s, mode_s_n;
    logic [P-1:0] passes_s, passes_s_n;

    logic [P-1:0] pass_plus;
    logic [P-1:0] pass_sat;
    logic         last_pass;
    logic         illegal;

    assign pass_plus = pass_cnt + ONE_P;
    // Continuous mode keeps counting half-sweeps, so hold at all-ones.
    assign pass_sat  = (pass_cnt == '1) ? pass_cnt : pass_plus;
    assign last_pass = (mode_s == M_COUNT) && (pass_plus == passes_s);
    assign illegal   = (bus.lo >= bus.hi) ||
                       ((bus.mode == M_COUNT) && (bus.passes == '0));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            q_r      <= '0;
            updown_r <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            pass_cnt <= '0;
            lo_s     <= '0;
            hi_s     <= '0;
            mode_s   <= '0;
            passes_s <= '0;
        end else begin
            state    <= state_n;
            q_r      <= q_n;
            updown_r <= updown_n;
            busy_r   <= busy_n;
            done_r   <= done_n;
            err_r    <= err_n;
            pass_cnt <= pass_cnt_n;
            lo_s     <= lo_s_n;
            hi_s     <= hi_s_n;
            mode_s   <= mode_s_n;
            passes_s <= passes_s_n;
        end
    end

    always_comb begin
        state_n    = state;
        q_n        = q_r;
        updown_n   = updown_r;
        busy_n     = busy_r;
        done_n     = 1'b0;
        err_n      = 1'b0;
        pass_cnt_n = pass_cnt;
        lo_s_n     = lo_s;
        hi_s_n     = hi_s;
        mode_s_n   = mode_s;
        passes_s_n = passes_s;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    lo_s_n     = bus.lo;
                    hi_s_n     = bus.hi;
                    mode_s_n   = bus.mode;
                    passes_s_n = bus.passes;
                    if (illegal) begin
                        err_n = 1'b1;
                    end else begin
                        busy_n     = 1'b1;
                        pass_cnt_n = '0;
                        if (bus.mode == M_DOWN) begin
                            q_n      = bus.hi;
                            updown_n = 1'b0;
                            state_n  = DOWN;
                        end else begin
                            q_n      = bus.lo;
                            updown_n = 1'b1;
                            state_n  = UP;
                        end
                    end
                end
            end

            UP: begin
                if (bus.stop) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else if (!bus.pause) begin
                    if (q_r != hi_s) begin
                        q_n = q_r + ONE_N;
                    end else begin
                        pass_cnt_n = pass_sat;
                        if ((mode_s == M_UP) || last_pass) begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            // Bound was already shown this cycle, so skip the dwell.
                            state_n  = DOWN;
                            updown_n = 1'b0;
                            q_n      = hi_s - ONE_N;
                        end
                    end
                end
            end

            DOWN: begin
                if (bus.stop) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else if (!bus.pause) begin
                    if (q_r != lo_s) begin
                        q_n = q_r - ONE_N;
                    end else begin
                        pass_cnt_n = pass_sat;
                        if ((mode_s == M_DOWN) || last_pass) begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            state_n  = UP;
                            updown_n = 1'b1;
                            q_n      = lo_s + ONE_N;
                        end
                    end
                end
            end

            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign bus.q      = q_r;
    assign bus.updown = updown_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.err    = err_r;
endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
- Sequencer for an N-bit up/down counter datapath; the counter register lives inside this block.
- Sweeps the count between programmable bounds lo and hi: single up, single down, a fixed number of ping-pong half-sweeps, or continuous ping-pong.
- Drives the count value and direction to downstream logic.
- Gives start/stop/pause control and busy/done/err status to a host FSM.

Parameters:
- N, 4, counter width in bits.
- P, 4, width of the half-sweep (pass) count.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous active-high reset.
- start  in  1  launch a sweep; sampled only in IDLE.
- stop  in  1  abort the sweep; returns to IDLE next edge.
- pause  in  1  freeze count, state and pass count while high.
- mode  in  2  00 single up, 01 single down, 10 counted ping-pong, 11 continuous ping-pong.
- lo  in  N  lower bound (unsigned), sampled at start.
- hi  in  N  upper bound (unsigned), sampled at start.
- passes  in  P  half-sweeps for mode 10, sampled at start.
- q  out  N  current count.
- updown  out  1  1 = counting up, 0 = counting down.
- busy  out  1  high in UP/DOWN.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse on an illegal start.

Behaviour:
- All outputs are registered.
- clr=1 (async, any time, including mid-sweep): state IDLE, q=0, updown=1, busy=0, done=0, err=0, pass_cnt=0, shadow lo/hi/mode/passes=0.
- States: IDLE, UP, DOWN. done and err default to 0 on every edge unless set below.
- IDLE, start=1: latch lo, hi, mode, passes into shadow regs.
  - Error case: lo>=hi, or mode=10 with passes=0. Pulse err, stay IDLE, q and updown unchanged.
  - Mode 01: q<=hi, updown<=0, go to DOWN.
  - Other modes: q<=lo, updown<=1, go to UP.
  - Legal start: busy<=1, pass_cnt<=0.
- IDLE, start=0: hold everything.
- UP/DOWN priority per edge: stop > pause > count.
- stop=1: go to IDLE, busy<=0, q holds, no done pulse.
- pause=1 (stop=0): no change at all; busy stays 1.
- UP, q!=hi: q<=q+1.
- UP, q==hi (half-sweep end): pass_cnt<=pass_cnt+1, then:
  - mode 00: complete.
  - mode 10 and pass_cnt+1==passes: complete.
  - otherwise: go to DOWN, updown<=0, q<=hi-1 (no dwell).
- DOWN: mirror image of UP with lo. Mode 01 completes at q==lo. Turnaround gives q<=lo+1, updown<=1.
- Complete: go to IDLE, busy<=0, done<=1 for one cycle, q holds the final bound.
- Mode 11 never completes; pass_cnt saturates at all-ones. Only stop or clr exits.
- Every value between lo and hi occupies q for exactly one cycle when pause=0; each bound appears once per turnaround.
- q never leaves [lo,hi] while busy, so no wrap-around occurs. Arithmetic is N-bit unsigned.
- start while busy is ignored; shadow regs do not change mid-sweep.
- Latency: start edge loads the first bound; the first step is on the next edge. A mode-00 sweep of k=hi-lo steps asserts done on edge k+1 after the start edge.
- stop and start both high in IDLE: start wins (stop is meaningful only when busy).

Test Plan:
- Reset mid-sweep: mode 11, lo=2, hi=9, assert clr while q=5 -> q=0, busy=0, updown=1 immediately (async); IDLE after release.
- Single up: mode 00, lo=3, hi=6, start one cycle -> q=3,4,5,6 on consecutive edges; next edge done=1 for one cycle, busy=0, q=6 holds.
- Counted ping-pong: mode 10, lo=1, hi=3, passes=3 -> q=1,2,3,2,1,2,3; done pulses on the edge after q=3; updown toggles at each turnaround.
- Single down with pause: mode 01, lo=0, hi=4, pause held 2 cycles at q=2 -> q=4,3,2,2,2,1,0, then done; busy stays 1 during pause.
- Illegal start: lo=5, hi=5 mode 00 -> err pulse, busy=0, q unchanged. Mode 10 with passes=0 -> err pulse. start while busy -> ignored, sweep continues.
- Stop priority and wrap: mode 11, lo=0, hi=15 (N=4), stop and pause together at q=15 -> IDLE, q=15, no done; confirm q never wraps 15->0.
